// File: rtl/wb_stage.sv
// Writeback stage: aligns/extends load data, merges divider completions through a
// one-entry holding register, and drives the register file write port plus bypass.
module wb_stage #(
    parameter int BITS      = 32,
    parameter int WORDS     = 32,
    parameter int ADDR_LEFT = $clog2(WORDS) - 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pipe_valid,
    input  logic [ADDR_LEFT:0] pipe_waddr,
    input  logic [BITS-1:0]    pipe_data,
    input  logic               pipe_load,
    input  logic [1:0]         pipe_size,
    input  logic               pipe_unsigned,
    input  logic [1:0]         pipe_addr_lo,
    input  logic               div_valid,
    output logic               div_ready,
    input  logic [ADDR_LEFT:0] div_waddr,
    input  logic [BITS-1:0]    div_wdata,
    output logic               rw_,
    output logic [ADDR_LEFT:0] waddr,
    output logic [BITS-1:0]    wdata,
    output logic [3:0]         byte_en,
    output logic               fwd_valid,
    output logic [ADDR_LEFT:0] fwd_addr,
    output logic [BITS-1:0]    fwd_data,
    output logic               misalign,
    output logic               div_drop
);

    logic [BITS-1:0]    load_val;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic               aligned;
    logic               pipe_wr;
    logic               pipe_mis;
    logic               div_xfer;

    logic               hold_full;
    logic [ADDR_LEFT:0] hold_addr;
    logic [BITS-1:0]    hold_data;
    logic               hold_full_nxt;
    logic [ADDR_LEFT:0] hold_addr_nxt;
    logic [BITS-1:0]    hold_data_nxt;

    logic               wr_en;
    logic [ADDR_LEFT:0] wr_addr;
    logic [BITS-1:0]    wr_data;
    logic               drop;

    // Load alignment: pick the addressed byte/half and extend to a full word.
    always_comb begin
        load_val = pipe_data;
        aligned  = 1'b1;
        byte_sel = pipe_data[8*pipe_addr_lo +: 8];
        half_sel = pipe_addr_lo[1] ? pipe_data[31:16] : pipe_data[15:0];
        if (pipe_load) begin
            case (pipe_size)
                2'b00: load_val = {{(BITS-8){byte_sel[7] & ~pipe_unsigned}}, byte_sel};
                2'b01: begin
                    load_val = {{(BITS-16){half_sel[15] & ~pipe_unsigned}}, half_sel};
                    aligned  = ~pipe_addr_lo[0];
                end
                default: aligned = (pipe_addr_lo == 2'b00);
            endcase
        end
    end

    // Divider handshake: a result transfers on any edge where div_valid && div_ready;
    // div_ready is simply "holding register empty", and the divider keeps div_*
    // stable while div_valid is high and div_ready is low.
    assign div_ready = ~hold_full;
    assign div_xfer  = div_valid & div_ready;
    assign pipe_mis  = pipe_valid & pipe_load & ~aligned;
    assign pipe_wr   = pipe_valid & aligned & (pipe_waddr != '0);

    // Port arbitration: pipe, then held divider entry, then a direct divider result.
    always_comb begin
        wr_en         = 1'b0;
        wr_addr       = pipe_waddr;
        wr_data       = load_val;
        drop          = 1'b0;
        hold_full_nxt = hold_full;
        hold_addr_nxt = hold_addr;
        hold_data_nxt = hold_data;
        if (pipe_wr) begin
            wr_en = 1'b1;
            if (hold_full && (hold_addr == pipe_waddr)) begin
                hold_full_nxt = 1'b0;
                drop          = 1'b1;
            end
            if (div_xfer && (div_waddr != '0)) begin
                if (div_waddr == pipe_waddr) begin
                    drop = 1'b1;
                end else begin
                    hold_full_nxt = 1'b1;
                    hold_addr_nxt = div_waddr;
                    hold_data_nxt = div_wdata;
                end
            end
        end else if (hold_full) begin
            wr_en         = 1'b1;
            wr_addr       = hold_addr;
            wr_data       = hold_data;
            hold_full_nxt = 1'b0;
        end else if (div_xfer && (div_waddr != '0)) begin
            wr_en   = 1'b1;
            wr_addr = div_waddr;
            wr_data = div_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rw_       <= 1'b1;
            waddr     <= '0;
            wdata     <= '0;
            byte_en   <= 4'b1111;
            misalign  <= 1'b0;
            div_drop  <= 1'b0;
            hold_full <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
        end else begin
            rw_       <= ~wr_en;
            byte_en   <= 4'b1111;
            misalign  <= pipe_mis;
            div_drop  <= drop;
            hold_full <= hold_full_nxt;
            hold_addr <= hold_addr_nxt;
            hold_data <= hold_data_nxt;
            if (wr_en) begin
                waddr <= wr_addr;
                wdata <= wr_data;
            end
        end
    end

    // Bypass covers the cycle between driving the port and the regfile commit.
    assign fwd_valid = ~rw_;
    assign fwd_addr  = waddr;
    assign fwd_data  = wdata;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage directly upstream of the 2-read/1-write register file; it owns the register file write port (rw_, waddr, wdata, byte_en).
- Takes the retiring instruction from the MEM stage and aligns and extends load data.
- Merges completions from the multi-cycle divider into the single write port through a one-entry holding register.
- Drives a bypass port carrying the value being written this cycle.

Parameters:
BITS, 32, data word width (load alignment logic fixed for 32)
WORDS, 32, register count
ADDR_LEFT, $clog2(WORDS)-1, MSB of register address

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pipe_valid  in  1  MEM stage retiring an instruction this cycle (no backpressure)
pipe_waddr  in  ADDR_LEFT+1  destination register
pipe_data  in  BITS  ALU result or raw 32-bit load word
pipe_load  in  1  1 = load, apply alignment
pipe_size  in  2  00 byte, 01 half, 10/11 word
pipe_unsigned  in  1  1 = zero-extend, 0 = sign-extend
pipe_addr_lo  in  2  load byte offset
div_valid  in  1  divider result offered
div_ready  out  1  holding register empty
div_waddr  in  ADDR_LEFT+1  divider destination
div_wdata  in  BITS  divider result
rw_  out  1  regfile write strobe, 0 = write
waddr  out  ADDR_LEFT+1  regfile write address
wdata  out  BITS  regfile write data
byte_en  out  4  regfile byte enables
fwd_valid  out  1  bypass valid (equals !rw_)
fwd_addr, fwd_data  out  ADDR_LEFT+1, BITS  bypass address/data (mirror waddr/wdata)
misalign  out  1  one-cycle pulse: misaligned load dropped
div_drop  out  1  one-cycle pulse: held divider result discarded

Behaviour:
- Reset (rst high at posedge): rw_=1, waddr=0, wdata=0, byte_en=4'b1111, misalign=0, div_drop=0, holding register empty (div_ready=1). rst overrides every other input that cycle. A held result is lost.
- All write-port outputs are registered.
  - Inputs at edge N drive the port during cycle N+1.
  - The regfile commits at edge N+1.
  - Regfile readers see the value after edge N+1; the fwd_* port covers the gap during cycle N+1.
- byte_en is always 4'b1111. Loads are extended to the full word here.
- Load alignment (pipe_load=1):
  - Byte: pipe_data[8*lo +: 8], extended.
  - Half: lo=00 takes [15:0], lo=10 takes [31:16], extended. lo[0]=1 is misaligned.
  - Word: lo must be 00, otherwise misaligned.
  - Misaligned: no write (rw_=1 next cycle), misalign=1 next cycle.
- Non-load: wdata = pipe_data unmodified.
- Address 0 writes are suppressed (rw_ stays 1, fwd_valid=0) from both sources. Divider results for address 0 are still accepted, then dropped silently.
- Source priority, evaluated each edge:
  1. A valid, aligned pipe_valid with nonzero address wins the port.
  2. Else the holding register drains if full.
  3. Else a direct div_valid && div_ready is written straight through without occupying the holding register.
  4. Else idle (rw_=1).
- Divider handshake: a transfer occurs at an edge with div_valid && div_ready.
  - If the port is taken by the pipe that cycle, the result loads into the holding register and div_ready drops next cycle.
  - div_ready rises the cycle after the holding register drains.
  - The divider holds div_* stable while div_valid && !div_ready.
- WAW:
  - A pipe write (aligned, nonzero address) to the same address as the held divider entry discards that entry: div_drop=1 next cycle, holding register empty next cycle.
  - A divider result arriving the same edge as a pipe write to the same address is accepted and discarded the same way.
- Misaligned pipe loads do not claim the port; the holding register or divider may use that slot.

Test Plan:
- Loads with pipe_data=32'h8899AABB: byte lo=01 signed -> wdata=32'hFFFFFFAA; lo=00 unsigned -> 32'h000000BB; half lo=10 signed -> 32'hFFFF8899. Each has rw_=0 exactly one cycle after input.
- Half load lo=01 to r5 -> rw_ stays 1, misalign pulses 1 cycle. A div result offered that cycle is written instead.
- pipe writes r3 every cycle for 3 cycles while div offers r7=32'h1234 -> held, div_ready=0; r7 written the first idle cycle, div_ready=1 the cycle after.
- div held for r9, then pipe writes r9=32'h5 -> div_drop pulses, regfile r9 ends 32'h5, div_ready returns 1.
- pipe_waddr=0 and div_waddr=0 -> rw_ never 0, fwd_valid never 1, div_ready stays 1.
- rst asserted with holding register full -> next cycle rw_=1, div_ready=1, held result never written.
